point_double_ctrl: RTL and testbench

Sequencer for twisted-Edwards (a = −1, p = 2^255−19) projective point doubling, built around one shared external 256-bit field multiplier. It latches (X1,Y1,Z1), issues seven multiplications over a req/ack handshake, performs the adds and subtracts with an internal modular add/sub unit, and returns (X3,Y3,Z3). It replaces the fully combinational doubling datapath, which instantiates seven multipliers, in the x25519 scalar-multiplication loop.

---
 rtl/point_double_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_point_double_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/point_double_ctrl.sv
// Projective point-doubling sequencer for twisted Edwards (a = -1) over 2^255-19.
// Drives one shared external multiplier and does the adds and subtracts locally.
module point_double_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] x1,
   input  logic [255:0] y1,
   input  logic [255:0] z1,
   output logic         busy,
   output logic         done,
   output logic [255:0] x2,
   output logic [255:0] y2,
   output logic [255:0] z2,
   output logic         mul_req,
   output logic [255:0] mul_a,
   output logic [255:0] mul_b,
   input  logic         mul_ack,
   input  logic [255:0] mul_result
);

   localparam int unsigned W  = 256;
   localparam int unsigned SW = 4;
   localparam logic [W-1:0] P =
      256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
   localparam logic [SW-1:0] LAST_STEP = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_STEP = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [SW-1:0]   r_step;
   logic [SW-1:0]   w_step_nxt;
   logic            r_gap;
   logic            w_gap_nxt;

   logic            w_is_mul;
   logic            w_as_en;
   logic            w_cap;
   logic            w_req_nxt;
   logic            w_busy_nxt;
   logic            w_done_nxt;
   logic            w_issue;

   logic [W-1:0]    w_as_a;
   logic [W-1:0]    w_as_b;
   logic            w_as_sub;
   logic [W-1:0]    w_as_res;
   logic [W-1:0]    w_t_fwd;
   logic [W-1:0]    w_op_a;
   logic [W-1:0]    w_op_b;

   logic            r_busy;
   logic            r_done;
   logic            r_mul_req;
   logic [W-1:0]    r_mul_a;
   logic [W-1:0]    r_mul_b;
   logic [W-1:0]    r_x2;
   logic [W-1:0]    r_y2;
   logic [W-1:0]    r_z2;

   logic [W-1:0]    r_x1;
   logic [W-1:0]    r_y1;
   logic [W-1:0]    r_z1;
   logic [W-1:0]    r_t;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_c;
   logic [W-1:0]    r_d;
   logic [W-1:0]    r_h;
   logic [W-1:0]    r_e;
   logic [W-1:0]    r_f;
   logic [W-1:0]    r_j;
   logic [W-1:0]    r_g;
   logic [W-1:0]    r_k;
   logic [W-1:0]    r_x3;
   logic [W-1:0]    r_y3;
   logic [W-1:0]    r_z3;

   assign busy    = r_busy;
   assign done    = r_done;
   assign mul_req = r_mul_req;
   assign mul_a   = r_mul_a;
   assign mul_b   = r_mul_b;
   assign x2      = r_x2;
   assign y2      = r_y2;
   assign z2      = r_z2;

   // Steps that go through the external multiplier.
   function automatic logic is_mul_step(input logic [SW-1:0] s);
      logic m;
      case (s)
         4'd2, 4'd3, 4'd4, 4'd5, 4'd13, 4'd14, 4'd15: m = 1'b1;
         default:                                     m = 1'b0;
      endcase
      return m;
   endfunction

   // Modular add/sub; both operands are already reduced below P.
   function automatic logic [W-1:0] mod_addsub(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic         sub);
      logic [W:0] s;
      if (sub) begin
         s = {1'b0, a} - {1'b0, b};
         if (s[W]) s = s + {1'b0, P};
      end else begin
         s = {1'b0, a} + {1'b0, b};
         if (s >= {1'b0, P}) s = s - {1'b0, P};
      end
      return s[W-1:0];
   endfunction

   assign w_is_mul = is_mul_step(r_step);

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_step  <= '0;
         r_gap   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;
         r_gap   <= w_gap_nxt;
      end
   end

   // Next state; a multiply step is request-until-ack followed by one idle cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_gap_nxt   = r_gap;
      w_as_en     = 1'b0;
      w_cap       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_STEP;
               w_step_nxt  = 4'd1;
               w_gap_nxt   = 1'b0;
            end
         end
         S_STEP: begin
            if (!w_is_mul) begin
               w_as_en    = 1'b1;
               w_step_nxt = r_step + 4'd1;
            end else if (!r_gap) begin
               if (r_mul_req && mul_ack) begin
                  w_cap     = 1'b1;
                  w_gap_nxt = 1'b1;
               end
            end else begin
               w_gap_nxt = 1'b0;
               if (r_step == LAST_STEP) w_state_nxt = S_DONE;
               else                     w_step_nxt  = r_step + 4'd1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      w_req_nxt  = (w_state_nxt == S_STEP) && is_mul_step(w_step_nxt) && !w_gap_nxt;
      w_busy_nxt = (w_state_nxt != S_IDLE);
      w_done_nxt = (w_state_nxt == S_DONE);
   end

   assign w_issue = w_req_nxt && !r_mul_req;

   // Add/sub operand selection for the single-cycle steps.
   always_comb begin
      w_as_a   = '0;
      w_as_b   = '0;
      w_as_sub = 1'b0;
      case (r_step)
         4'd1:  begin w_as_a = r_x1; w_as_b = r_y1; end
         4'd6:  begin w_as_a = '0;   w_as_b = r_c;  w_as_sub = 1'b1; end
         4'd7:  begin w_as_a = r_e;  w_as_b = r_d;  end
         4'd8:  begin w_as_a = r_f;  w_as_b = r_h;  w_as_sub = 1'b1; end
         4'd9:  begin w_as_a = r_j;  w_as_b = r_h;  w_as_sub = 1'b1; end
         4'd10: begin w_as_a = r_b;  w_as_b = r_c;  w_as_sub = 1'b1; end
         4'd11: begin w_as_a = r_g;  w_as_b = r_d;  w_as_sub = 1'b1; end
         4'd12: begin w_as_a = r_e;  w_as_b = r_d;  w_as_sub = 1'b1; end
         default: begin end
      endcase
   end

   assign w_as_res = mod_addsub(w_as_a, w_as_b, w_as_sub);

   // T is produced in the same cycle that the first multiply is issued.
   assign w_t_fwd = (w_as_en && (r_step == 4'd1)) ? w_as_res : r_t;

   always_comb begin
      w_op_a = '0;
      w_op_b = '0;
      case (w_step_nxt)
         4'd2:  begin w_op_a = w_t_fwd; w_op_b = w_t_fwd; end
         4'd3:  begin w_op_a = r_x1;    w_op_b = r_x1;    end
         4'd4:  begin w_op_a = r_y1;    w_op_b = r_y1;    end
         4'd5:  begin w_op_a = r_z1;    w_op_b = r_z1;    end
         4'd13: begin w_op_a = r_g;     w_op_b = r_j;     end
         4'd14: begin w_op_a = r_f;     w_op_b = r_k;     end
         4'd15: begin w_op_a = r_f;     w_op_b = r_j;     end
         default: begin end
      endcase
   end

   // Datapath registers, temporaries and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_mul_req <= 1'b0;
         r_mul_a   <= '0;
         r_mul_b   <= '0;
         r_x2      <= '0;
         r_y2      <= '0;
         r_z2      <= '0;
         r_x1      <= '0;
         r_y1      <= '0;
         r_z1      <= '0;
         r_t       <= '0;
         r_b       <= '0;
         r_c       <= '0;
         r_d       <= '0;
         r_h       <= '0;
         r_e       <= '0;
         r_f       <= '0;
         r_j       <= '0;
         r_g       <= '0;
         r_k       <= '0;
         r_x3      <= '0;
         r_y3      <= '0;
         r_z3      <= '0;
      end else begin
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_mul_req <= w_req_nxt;
         if ((r_state == S_IDLE) && start) begin
            r_x1 <= x1;
            r_y1 <= y1;
            r_z1 <= z1;
         end
         if (w_as_en) begin
            case (r_step)
               4'd1:       r_t <= w_as_res;
               4'd6:       r_e <= w_as_res;
               4'd7:       r_f <= w_as_res;
               4'd8, 4'd9: r_j <= w_as_res;
               4'd10, 4'd11: r_g <= w_as_res;
               4'd12:      r_k <= w_as_res;
               default: begin end
            endcase
         end
         if (w_cap) begin
            case (r_step)
               4'd2:  r_b  <= mul_result;
               4'd3:  r_c  <= mul_result;
               4'd4:  r_d  <= mul_result;
               4'd5:  r_h  <= mul_result;
               4'd13: r_x3 <= mul_result;
               4'd14: r_y3 <= mul_result;
               4'd15: r_z3 <= mul_result;
               default: begin end
            endcase
         end
         if (w_issue) begin
            r_mul_a <= w_op_a;
            r_mul_b <= w_op_b;
         end
         if (w_done_nxt) begin
            r_x2 <= r_x3;
            r_y2 <= r_y3;
            r_z2 <= r_z3;
         end
      end
   end

endmodule

// File: tb/tb_point_double_ctrl.sv
// Self-checking bench for point_double_ctrl: constant vectors, random points with
// random multiplier latency against a modular-arithmetic model, and corner sequences.
module tb_point_double_ctrl;

   localparam logic [255:0] P =
      256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [255:0] x1, y1, z1;
   logic         busy, done;
   logic [255:0] x2, y2, z2;
   logic         mul_req;
   logic [255:0] mul_a, mul_b;
   logic         mul_ack;
   logic [255:0] mul_result;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   point_double_ctrl dut (
      .clk(clk), .rst(rst), .start(start),
      .x1(x1), .y1(y1), .z1(z1),
      .busy(busy), .done(done),
      .x2(x2), .y2(y2), .z2(z2),
      .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
      .mul_ack(mul_ack), .mul_result(mul_result)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [255:0] x, y, z;
      logic [255:0] ex, ey, ez;
      int           lat;
      int           dcyc;
   } vec_t;

   function automatic logic [255:0] madd(input logic [255:0] a, input logic [255:0] b);
      logic [256:0] s;
      s = 257'(a) + 257'(b);
      s = s % 257'(P);
      return s[255:0];
   endfunction

   function automatic logic [255:0] msub(input logic [255:0] a, input logic [255:0] b);
      logic [256:0] s;
      s = 257'(a) + 257'(P) - 257'(b);
      s = s % 257'(P);
      return s[255:0];
   endfunction

   function automatic logic [255:0] mmul(input logic [255:0] a, input logic [255:0] b);
      logic [511:0] p;
      p = 512'(a) * 512'(b);
      p = p % 512'(P);
      return p[255:0];
   endfunction

   function automatic logic [255:0] rnd_fe();
      logic [255:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      r[255] = 1'b0;
      if (r >= P) r = r - P;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk256(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, got, exp);
      end
   endtask

   task automatic chki(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // One doubling: acts as the multiplier (latency lat_fix, or random 1..6 when 0)
   // and checks operands, stability, timing and result against the formula model.
   task automatic run_double(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z,
                             input int lat_fix, input int rst_cyc, input bit spur, input bit inj,
                             output logic [255:0] gx, output logic [255:0] gy,
                             output logic [255:0] gz, output int dcyc);
      logic [255:0] t, b, c, d, h, e, f, j, g, k, x3, y3, z3;
      logic [255:0] ea [7];
      logic [255:0] eb [7];
      logic [255:0] ha, hb;
      int  lat, cnt, idx, sum;
      bit  pend, ack_prev, seen;
      t  = madd(x, y);
      b  = mmul(t, t);
      c  = mmul(x, x);
      d  = mmul(y, y);
      h  = mmul(z, z);
      e  = msub(256'd0, c);
      f  = madd(e, d);
      j  = msub(f, madd(h, h));
      g  = msub(b, madd(c, d));
      k  = msub(e, d);
      x3 = mmul(g, j);
      y3 = mmul(f, k);
      z3 = mmul(f, j);
      ea = '{t, x, y, z, g, f, f};
      eb = '{t, x, y, z, j, k, j};
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_done", done, 1'b0);
      gx = '0; gy = '0; gz = '0; dcyc = -1;
      sum = 0; idx = 0; lat = 1; cnt = 0;
      pend = 1'b0; ack_prev = 1'b0; seen = 1'b0;
      ha = '0; hb = '0;
      start = 1'b1; x1 = x; y1 = y; z1 = z;
      cyc = 0;
      tick();
      start = 1'b0; x1 = rnd_fe(); y1 = rnd_fe(); z1 = rnd_fe();
      while (!seen && cyc < 3000) begin
         mul_ack = 1'b0;
         start   = 1'b0;
         if (spur && cyc == 1) begin
            mul_ack    = 1'b1;
            mul_result = rnd_fe();
         end
         if (inj && (cyc == 5 || cyc == 22)) begin
            start = 1'b1; x1 = rnd_fe(); y1 = rnd_fe(); z1 = rnd_fe();
         end
         if (cyc == rst_cyc) begin
            chk1("req_high_at_rst", mul_req, 1'b1);
            mul_ack = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_done", done, 1'b0);
            chk1("rst_req", mul_req, 1'b0);
            chk256("rst_x2", x2, 256'd0);
            chk256("rst_y2", y2, 256'd0);
            chk256("rst_z2", z2, 256'd0);
            chk256("rst_mul_a", mul_a, 256'd0);
            chk256("rst_mul_b", mul_b, 256'd0);
            return;
         end
         if (ack_prev) chk1("req_low_after_ack", mul_req, 1'b0);
         ack_prev = 1'b0;
         if (done) begin
            seen = 1'b1;
            dcyc = cyc;
            gx = x2; gy = y2; gz = z2;
            chk1("busy_in_done", busy, 1'b1);
         end else if (mul_req) begin
            if (!pend) begin
               pend = 1'b1;
               cnt  = 1;
               lat  = (lat_fix > 0) ? lat_fix : int'($urandom_range(6, 1));
               sum += lat + 1;
               ha = mul_a; hb = mul_b;
               if (idx < 7) begin
                  chk256($sformatf("op_a%0d", idx), mul_a, ea[idx]);
                  chk256($sformatf("op_b%0d", idx), mul_b, eb[idx]);
               end else begin
                  n_tests++; n_fail++;
                  $display("FAIL extra_request: got request %0d, expected at most 7", idx + 1);
               end
               idx++;
            end else begin
               cnt++;
               chk256("mul_a_stable", mul_a, ha);
               chk256("mul_b_stable", mul_b, hb);
            end
            if (cnt == lat) begin
               mul_ack    = 1'b1;
               mul_result = mmul(mul_a, mul_b);
               pend       = 1'b0;
               ack_prev   = 1'b1;
            end
         end
         if (!seen) tick();
      end
      mul_ack = 1'b0;
      start   = 1'b0;
      if (!seen) begin
         n_tests++; n_fail++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
      end else begin
         chk256("model_x2", gx, x3);
         chk256("model_y2", gy, y3);
         chk256("model_z2", gz, z3);
         chki("done_cycle", dcyc, 9 + sum);
         chki("mul_count", idx, 7);
      end
      tick();
      chk1("done_one_cycle", done, 1'b0);
      chk1("busy_after_done", busy, 1'b0);
      chk256("x2_hold", x2, gx);
   endtask

   initial begin
      vec_t         tbl [6];
      logic [255:0] gx, gy, gz;
      int           dc;

      tbl[0] = '{256'd0, 256'd1, 256'd1, 256'd0, P - 256'd1, P - 256'd1, 1, 23};
      tbl[1] = '{256'd1, 256'd0, 256'd1, 256'd0, 256'd1, 256'd3, 1, 23};
      tbl[2] = '{256'd0, 256'd1, 256'd1, 256'd0, P - 256'd1, P - 256'd1, 3, 37};
      tbl[3] = '{256'd1, 256'd0, 256'd1, 256'd0, 256'd1, 256'd3, 2, 30};
      tbl[4] = '{256'd0, 256'd1, 256'd0, 256'd0, P - 256'd1, 256'd1, 1, 23};
      tbl[5] = '{P - 256'd1, 256'd0, 256'd1, 256'd0, 256'd1, 256'd3, 2, 30};

      rst = 1'b1; start = 1'b0; mul_ack = 1'b0;
      x1 = '0; y1 = '0; z1 = '0; mul_result = '0;
      tick();
      tick();
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_done", done, 1'b0);
      chk1("reset_req", mul_req, 1'b0);
      chk256("reset_x2", x2, 256'd0);
      chk256("reset_mul_a", mul_a, 256'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_double(tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].lat, -1, 1'b0, 1'b0, gx, gy, gz, dc);
         chk256($sformatf("vec%0d_x2", i), gx, tbl[i].ex);
         chk256($sformatf("vec%0d_y2", i), gy, tbl[i].ey);
         chk256($sformatf("vec%0d_z2", i), gz, tbl[i].ez);
         chki($sformatf("vec%0d_done", i), dc, tbl[i].dcyc);
      end

      for (int i = 0; i < 6; i++) begin
         run_double(rnd_fe(), rnd_fe(), rnd_fe(), 0, -1, 1'b0, 1'b0, gx, gy, gz, dc);
      end

      // start pulses at cycles 5 and 22 are ignored; the next start lands in cycle 24
      run_double(rnd_fe(), rnd_fe(), rnd_fe(), 1, -1, 1'b0, 1'b1, gx, gy, gz, dc);
      chki("inj_done_cycle", dc, 23);
      run_double(rnd_fe(), rnd_fe(), rnd_fe(), 1, -1, 1'b0, 1'b0, gx, gy, gz, dc);
      chki("restart_done_cycle", dc, 23);

      // reset mid-run while a request is outstanding, then a clean run
      run_double(rnd_fe(), rnd_fe(), rnd_fe(), 3, 10, 1'b0, 1'b0, gx, gy, gz, dc);
      run_double(256'd0, 256'd1, 256'd1, 1, -1, 1'b0, 1'b0, gx, gy, gz, dc);
      chki("post_rst_done", dc, 23);
      chk256("post_rst_y2", gy, P - 256'd1);

      // spurious ack while no request is pending
      run_double(256'd1, 256'd0, 256'd1, 1, -1, 1'b1, 1'b0, gx, gy, gz, dc);
      chki("spur_done", dc, 23);
      chk256("spur_x2", gx, 256'd0);
      chk256("spur_y2", gy, 256'd1);
      chk256("spur_z2", gz, 256'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
